// File: rtl/wb_fetch_arbiter_pkg.sv
// Shared CPU bus definitions: owner/state encodings and the grant priority rule.
// The encodings double as the o_owner value seen by downstream decoders.
package wb_fetch_arbiter_pkg;

    localparam logic [1:0] OWN_IDLE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    localparam int WB_DATA_W = 32;

    // A starved fetch port beats the data port; otherwise data has priority.
    function automatic logic [1:0] arb_decide(input logic a_cyc,
                                              input logic b_cyc,
                                              input logic b_starved);
        logic [1:0] grant;
        grant = OWN_IDLE;
        if (b_cyc && b_starved) grant = OWN_B;
        else if (a_cyc)         grant = OWN_A;
        else if (b_cyc)         grant = OWN_B;
        return grant;
    endfunction

endpackage

// File: rtl/wb_fetch_arbiter_if.sv
// Wishbone bundle around the fetch arbiter: data port (a), fetch port (b), shared bus.
// slave = arbiter view, master = environment view (CPU masters plus bus target).
interface wb_fetch_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32
) ();
    import wb_fetch_arbiter_pkg::*;

    logic                     i_a_cyc, i_a_stb, i_a_we;
    logic [ADDRESS_WIDTH-1:0] i_a_addr;
    logic [WB_DATA_W-1:0]     i_a_data;
    logic                     o_a_ack, o_a_stall, o_a_err;

    logic                     i_b_cyc, i_b_stb, i_b_we;
    logic [ADDRESS_WIDTH-1:0] i_b_addr;
    logic [WB_DATA_W-1:0]     i_b_data;
    logic                     o_b_ack, o_b_stall, o_b_err;

    logic                     o_wb_cyc, o_wb_stb, o_wb_we;
    logic [ADDRESS_WIDTH-1:0] o_wb_addr;
    logic [WB_DATA_W-1:0]     o_wb_data;
    logic                     i_wb_ack, i_wb_stall, i_wb_err;

    logic [1:0]               o_owner;

    modport slave (
        input  i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data,
        output o_a_ack, o_a_stall, o_a_err,
        input  i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data,
        output o_b_ack, o_b_stall, o_b_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        input  i_wb_ack, i_wb_stall, i_wb_err,
        output o_owner
    );

    modport master (
        output i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data,
        input  o_a_ack, o_a_stall, o_a_err,
        output i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data,
        input  o_b_ack, o_b_stall, o_b_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        output i_wb_ack, i_wb_stall, i_wb_err,
        input  o_owner
    );

endinterface

// File: rtl/wb_fetch_arbiter.sv
// Two-master Wishbone arbiter: data port has priority, fetch port gets an anti-starvation grant.
// Grant lands 1 clock after the decision; handoff is bubble-free; non-owner sees stall=1.
module wb_fetch_arbiter
    import wb_fetch_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int STARVE_LIMIT  = 15
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    wb_fetch_arbiter_if.slave  bus
);

    localparam int SW_RAW = $clog2(STARVE_LIMIT + 1);
    localparam int SW     = (SW_RAW > 4) ? SW_RAW : 4;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] starve_cnt;
    logic          b_starved;

    assign b_starved = (starve_cnt == STARVE_MAX);

    // An owner keeps the bus for as long as its cyc is held; no mid-cycle preemption.
    always_comb begin
        state_d = arb_decide(bus.i_a_cyc, bus.i_b_cyc, b_starved);
        if (state_q == OWN_A && bus.i_a_cyc) state_d = OWN_A;
        if (state_q == OWN_B && bus.i_b_cyc) state_d = OWN_B;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= OWN_IDLE;
            starve_cnt <= '0;
        end else begin
            state_q <= state_d;
            if ((state_d == OWN_B && state_q != OWN_B) || !bus.i_b_cyc)
                starve_cnt <= '0;
            else if (state_q == OWN_A && !b_starved)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    logic [ADDRESS_WIDTH-1:0] sel_addr;

    always_comb begin
        bus.o_wb_cyc  = 1'b0;
        bus.o_wb_stb  = 1'b0;
        bus.o_wb_we   = bus.i_b_we;
        sel_addr      = bus.i_b_addr;
        bus.o_wb_data = bus.i_b_data;
        bus.o_a_ack   = 1'b0;
        bus.o_a_err   = 1'b0;
        bus.o_a_stall = 1'b1;
        bus.o_b_ack   = 1'b0;
        bus.o_b_err   = 1'b0;
        bus.o_b_stall = 1'b1;
        case (state_q)
            OWN_A: begin
                bus.o_wb_cyc  = bus.i_a_cyc;
                bus.o_wb_stb  = bus.i_a_stb;
                bus.o_wb_we   = bus.i_a_we;
                sel_addr      = bus.i_a_addr;
                bus.o_wb_data = bus.i_a_data;
                bus.o_a_ack   = bus.i_wb_ack;
                bus.o_a_err   = bus.i_wb_err;
                bus.o_a_stall = bus.i_wb_stall;
            end
            OWN_B: begin
                bus.o_wb_cyc  = bus.i_b_cyc;
                bus.o_wb_stb  = bus.i_b_stb;
                bus.o_b_ack   = bus.i_wb_ack;
                bus.o_b_err   = bus.i_wb_err;
                bus.o_b_stall = bus.i_wb_stall;
            end
            default: ;
        endcase
    end

    assign bus.o_wb_addr = sel_addr;
    assign bus.o_owner   = state_q;

endmodule

// File: tb/tb_wb_fetch_arbiter.sv
// Directed checks of the fetch arbiter: reset, priority, handoff, error, abort, starvation.
module tb_wb_fetch_arbiter;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 i_clk = ~i_clk;

    wb_fetch_arbiter_if #(.ADDRESS_WIDTH(32)) bus ();

    wb_fetch_arbiter #(.ADDRESS_WIDTH(32), .STARVE_LIMIT(15)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        bus.i_a_cyc = 0; bus.i_a_stb = 0; bus.i_a_we = 0;
        bus.i_a_addr = 32'h100; bus.i_a_data = 32'hAAAA_0001;
        bus.i_b_cyc = 0; bus.i_b_stb = 0; bus.i_b_we = 0;
        bus.i_b_addr = 32'h200; bus.i_b_data = 32'hBBBB_0002;
        bus.i_wb_ack = 0; bus.i_wb_stall = 0; bus.i_wb_err = 0;

        // Reset held with both masters requesting and a stray ack on the bus
        bus.i_a_cyc = 1; bus.i_a_stb = 1; bus.i_a_we = 1;
        bus.i_b_cyc = 1; bus.i_b_stb = 1;
        bus.i_wb_ack = 1;
        step(3);
        chk("rst_wb_cyc",  32'(bus.o_wb_cyc),  0);
        chk("rst_wb_stb",  32'(bus.o_wb_stb),  0);
        chk("rst_owner",   32'(bus.o_owner),   0);
        chk("rst_a_stall", 32'(bus.o_a_stall), 1);
        chk("rst_b_stall", 32'(bus.o_b_stall), 1);
        chk("rst_a_ack",   32'(bus.o_a_ack),   0);
        chk("rst_b_ack",   32'(bus.o_b_ack),   0);
        chk("idle_addr",   bus.o_wb_addr,      32'h200);

        // Release: simultaneous requests with counter 0 go to the data port
        bus.i_wb_ack = 0;
        i_rst_n = 1;
        step(1);
        chk("sim_owner",   32'(bus.o_owner),   1);
        chk("sim_addr",    bus.o_wb_addr,      32'h100);
        chk("sim_cyc",     32'(bus.o_wb_cyc),  1);
        chk("sim_we",      32'(bus.o_wb_we),   1);
        chk("sim_data",    bus.o_wb_data,      32'hAAAA_0001);
        chk("sim_b_stall", 32'(bus.o_b_stall), 1);

        bus.i_wb_stall = 1; #1;
        chk("a_stall_fwd", 32'(bus.o_a_stall), 1);
        bus.i_wb_stall = 0; bus.i_wb_ack = 1; #1;
        chk("a_ack_fwd",   32'(bus.o_a_ack),   1);
        chk("a_ack_b0",    32'(bus.o_b_ack),   0);
        chk("a_stall_0",   32'(bus.o_a_stall), 0);
        bus.i_wb_ack = 0;

        // Data port drops cyc: bus cyc falls at once, fetch granted next edge
        bus.i_a_cyc = 0; bus.i_a_stb = 0; #1;
        chk("a_drop_cyc",  32'(bus.o_wb_cyc),  0);
        step(1);
        chk("hand_owner",  32'(bus.o_owner),   2);
        chk("hand_addr",   bus.o_wb_addr,      32'h200);
        chk("hand_data",   bus.o_wb_data,      32'hBBBB_0002);

        // Error routed only to the owner
        bus.i_wb_err = 1; #1;
        chk("b_err",       32'(bus.o_b_err),   1);
        chk("b_err_a0",    32'(bus.o_a_err),   0);
        bus.i_wb_err = 0;
        bus.i_b_cyc = 0; bus.i_b_stb = 0;
        step(1);
        chk("b_rel_owner", 32'(bus.o_owner),   0);

        // Fetch abort mid-request, late ack lands in IDLE
        bus.i_b_cyc = 1; bus.i_b_stb = 1;
        step(1);
        chk("ab_owner",    32'(bus.o_owner),   2);
        step(1);
        bus.i_b_cyc = 0; bus.i_b_stb = 0; #1;
        chk("ab_cyc_now",  32'(bus.o_wb_cyc),  0);
        step(1);
        chk("ab_idle",     32'(bus.o_owner),   0);
        bus.i_wb_ack = 1; #1;
        chk("late_a_ack",  32'(bus.o_a_ack),   0);
        chk("late_b_ack",  32'(bus.o_b_ack),   0);
        bus.i_wb_ack = 0;

        // Reset in the middle of a data-port cycle
        bus.i_a_cyc = 1; bus.i_a_stb = 1;
        step(1);
        chk("mr_owner",    32'(bus.o_owner),   1);
        i_rst_n = 0;
        step(1);
        chk("mr_cyc",      32'(bus.o_wb_cyc),  0);
        chk("mr_owner0",   32'(bus.o_owner),   0);
        bus.i_wb_ack = 1; #1;
        chk("mr_ack",      32'(bus.o_a_ack),   0);
        bus.i_wb_ack = 0;
        i_rst_n = 1;

        // Starvation: data port holds the bus while fetch waits
        step(1);
        chk("st_owner_a",  32'(bus.o_owner),   1);
        bus.i_b_cyc = 1; bus.i_b_stb = 1;
        step(5);
        chk("st_cnt5",     32'(dut.starve_cnt), 5);
        step(15);
        chk("st_cnt_sat",  32'(dut.starve_cnt), 15);
        chk("st_hold_a",   32'(bus.o_owner),   1);
        bus.i_a_cyc = 0; bus.i_a_stb = 0;
        step(1);
        chk("st_grant_b",  32'(bus.o_owner),   2);
        chk("st_cnt_clr",  32'(dut.starve_cnt), 0);
        bus.i_a_cyc = 1; bus.i_a_stb = 1;
        step(1);
        chk("st_no_pre",   32'(bus.o_owner),   2);
        bus.i_b_cyc = 0; bus.i_b_stb = 0;
        step(1);
        chk("st_back_a",   32'(bus.o_owner),   1);
        chk("st_cnt_b0",   32'(dut.starve_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_fetch_arbiter.md
WB_FETCH_ARBITER -- requirements
Module: wb_fetch_arbiter

Interface
REQ-001 SHALL provide parameter ADDRESS_WIDTH, default 32: width of all address ports (AW).
REQ-002 SHALL provide parameter STARVE_LIMIT, default 15: max consecutive cycles the fetch port waits while the data port owns the bus.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 i_clk  in  1  sole clock, all state on rising edge.
REQ-005 i_rst_n  in  1  synchronous active-low reset.
REQ-006 i_a_cyc, i_a_stb, i_a_we  in  1 each  data-port (priority master) WB controls.
REQ-007 i_a_addr  in  AW; i_a_data  in  32  data-port address/write data.
REQ-008 o_a_ack, o_a_stall, o_a_err  out  1 each  data-port WB returns.
REQ-009 i_b_cyc, i_b_stb, i_b_we  in  1 each  fetch-port (instruction prefetch) WB controls.
REQ-010 i_b_addr  in  AW; i_b_data  in  32  fetch-port address/write data.
REQ-011 o_b_ack, o_b_stall, o_b_err  out  1 each  fetch-port WB returns.
REQ-012 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each; o_wb_addr  out  AW; o_wb_data  out  32  shared bus.
REQ-013 i_wb_ack, i_wb_stall, i_wb_err  in  1 each  shared-bus returns; read data goes to both masters directly, not through this block.
REQ-014 o_owner  out  2  current grant: 00 none, 01 data port, 10 fetch port.

Function
REQ-015 SHALL hold a registered state with states IDLE, OWN_A, OWN_B; o_owner encodes it.
REQ-016 Grant decision (from IDLE, or on owner's cyc low): if i_b_cyc and starve count == STARVE_LIMIT -> OWN_B; else if i_a_cyc -> OWN_A; else if i_b_cyc -> OWN_B; else IDLE.
REQ-017 While in OWN_x with i_x_cyc high, SHALL remain in OWN_x regardless of other requests (no preemption mid-cycle).
REQ-018 When owner's i_x_cyc is low, SHALL apply REQ-016 that same edge (zero-bubble handoff); a master's cycle reaches the bus 1 clock after grant decision.
REQ-019 Bus outputs SHALL be combinational from state: o_wb_cyc = i_x_cyc, o_wb_stb = i_x_stb, we/addr/data = owner's; in IDLE o_wb_cyc=o_wb_stb=0, addr/data/we = fetch port's values.
REQ-020 Owner: o_x_ack = i_wb_ack, o_x_err = i_wb_err, o_x_stall = i_wb_stall; non-owner: ack=0, err=0, stall=1.
REQ-021 Starve counter (4 bits min, width clog2(STARVE_LIMIT+1)): increments when state==OWN_A and i_b_cyc; saturates at STARVE_LIMIT; clears on entry to OWN_B or when i_b_cyc low.
REQ-022 Ack/err arriving while IDLE SHALL be ignored (no output asserted).
REQ-023 Fetch port dropping cyc mid-request (pc change) SHALL release bus same edge; outstanding ack is discarded by REQ-022 or routed to new owner only if it arrives after handoff — masters tolerate this as in WB abort.
REQ-024 Simultaneous first requests from both ports in IDLE with counter 0 SHALL grant data port.

Reset
REQ-025 i_rst_n low at a clock edge SHALL force IDLE and starve counter 0, overriding all other conditions, including mid-cycle.
REQ-026 After reset: o_wb_cyc=0, o_wb_stb=0, o_owner=00, o_a_ack=o_b_ack=0, o_a_err=o_b_err=0, o_a_stall=o_b_stall=1.
REQ-027 Reset mid-transaction SHALL drop o_wb_cyc in the cycle following the reset edge; no ack is forwarded afterwards.

Structure
REQ-028 State encodings (IDLE/OWN_A/OWN_B) SHALL live in the shared CPU bus package as constants reused by o_owner decoders.
REQ-029 Single flat module; no sub-modules, the starve counter is inline.

Verification
REQ-030 Reset: i_rst_n=0 with both cyc=1 for 3 clocks -> o_wb_cyc=0, o_owner=00, both stall=1; release -> o_owner=01 after 1 clock.
REQ-031 Simultaneous: a_cyc=b_cyc=1 from IDLE, a addr 0x100, b addr 0x200 -> o_wb_addr=0x100, o_b_stall=1; a drops cyc -> next edge o_owner=10, o_wb_addr=0x200.
REQ-032 Starvation: a_cyc held 20 clocks, b_cyc held -> counter reaches 15; on a's next cyc drop with a re-requesting -> grant OWN_B.
REQ-033 Error: owner B, i_wb_err=1 -> o_b_err=1, o_a_err=0; B drops cyc -> o_owner=00 or 01 next edge.
REQ-034 Mid-cycle abort: B owns, stb accepted, B drops cyc before ack -> o_wb_cyc=0 same cycle; late i_wb_ack in IDLE -> o_a_ack=o_b_ack=0.
